pe_border_ml: RTL and testbench

PE_BORDER_ML -- requirements
Module: pe_border_ml

---
 rtl/pe_pkg.sv | 13 +
 rtl/pe_lane.sv | 92 +++++++++
 rtl/pe_border_ml.sv | 85 ++++++++
 tb/tb_pe_border_ml.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and default sizes for the pe_border_ml processing element.
package pe_pkg;

    typedef enum logic {
        PE_MODE_WS = 1'b0,
        PE_MODE_OS = 1'b1
    } pe_mode_t;

    localparam int PE_IWIDTH = 8;
    localparam int PE_OWIDTH = 24;
    localparam int PE_LANES  = 4;

endpackage

// File: rtl/pe_lane.sv
// One MAC lane: ifm register, signed multiply, accumulator (chain or local).
// Optional feature macro: PE_SAT_EN (saturating sums plus sticky o_ovf).
module pe_lane
    import pe_pkg::*;
#(
    parameter int IWIDTH = PE_IWIDTH,
    parameter int OWIDTH = PE_OWIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en_ifm,
    input  logic                     i_clr_ifm,
    input  logic                     i_en_acc,
    input  logic                     i_clr_acc,
    input  pe_mode_t                 i_mode,
    input  logic signed [IWIDTH-1:0] i_ifm,
    input  logic signed [IWIDTH-1:0] i_wght,
    input  logic signed [OWIDTH-1:0] i_ofm,
    output logic signed [IWIDTH-1:0] o_ifm_d,
    output logic signed [OWIDTH-1:0] o_ofm_d
`ifdef PE_SAT_EN
    ,
    output logic                     o_ovf
`endif
);

    logic signed [IWIDTH-1:0]   r_ifm_d;
    logic signed [OWIDTH-1:0]   r_ofm_d;
    logic signed [2*IWIDTH-1:0] w_prod;
    logic signed [OWIDTH-1:0]   w_prod_ext;
    logic signed [OWIDTH-1:0]   w_addend;
    logic signed [OWIDTH-1:0]   w_acc_nxt;

    assign w_prod     = r_ifm_d * i_wght;
    assign w_prod_ext = {{(OWIDTH-2*IWIDTH){w_prod[2*IWIDTH-1]}}, w_prod};
    // WS adds the upstream partial sum; OS folds back onto our own accumulator.
    assign w_addend   = (i_mode == PE_MODE_OS) ? r_ofm_d : i_ofm;

`ifdef PE_SAT_EN
    logic signed [OWIDTH:0] w_sum;
    logic                   w_sat;
    logic                   r_ovf;

    assign w_sum = {w_addend[OWIDTH-1], w_addend} + {w_prod_ext[OWIDTH-1], w_prod_ext};

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_acc_nxt = w_sum[OWIDTH-1:0];
        w_sat     = 1'b0;
        if (w_sum[OWIDTH] != w_sum[OWIDTH-1]) begin
            w_sat     = 1'b1;
            w_acc_nxt = w_sum[OWIDTH] ? {1'b1, {(OWIDTH-1){1'b0}}}
                                      : {1'b0, {(OWIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr_acc) begin
            r_ovf <= 1'b0;
        end else if (i_en_acc && w_sat) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_ovf = r_ovf;
`else
    always_comb begin
        w_acc_nxt = w_addend + w_prod_ext;
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst || i_clr_ifm) begin
            r_ifm_d <= '0;
        end else if (i_en_ifm) begin
            r_ifm_d <= i_ifm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr_acc) begin
            r_ofm_d <= '0;
        end else if (i_en_acc) begin
            r_ofm_d <= w_acc_nxt;
        end
    end

    assign o_ifm_d = r_ifm_d;
    assign o_ofm_d = r_ofm_d;

endmodule

// File: rtl/pe_border_ml.sv
// Border PE: shared weight register, one-cycle control skew, LANES MAC lanes.
// Optional feature macro: PE_SAT_EN (saturation and the ovf output port).
module pe_border_ml
    import pe_pkg::*;
#(
    parameter int IWIDTH = PE_IWIDTH,
    parameter int OWIDTH = PE_OWIDTH,
    parameter int LANES  = PE_LANES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      clr_i,
    input  logic                      en_w,
    input  logic                      clr_w,
    input  logic                      en_o,
    input  logic                      clr_o,
    input  logic                      mode,
    input  logic [LANES*IWIDTH-1:0]   ifm,
    input  logic [IWIDTH-1:0]         wght,
    input  logic [LANES*OWIDTH-1:0]   ofm,
    output logic                      en_i_d,
    output logic                      clr_i_d,
    output logic                      en_w_d,
    output logic                      clr_w_d,
    output logic                      en_o_d,
    output logic                      clr_o_d,
    output logic                      mode_d,
    output logic [LANES*IWIDTH-1:0]   ifm_d,
    output logic [IWIDTH-1:0]         wght_d,
    output logic [LANES*OWIDTH-1:0]   ofm_d
`ifdef PE_SAT_EN
    ,
    output logic [LANES-1:0]          ovf
`endif
);

    logic [IWIDTH-1:0] r_wght_d;
    logic [6:0]        r_ctrl_d;

    always_ff @(posedge clk) begin
        if (rst || clr_w) begin
            r_wght_d <= '0;
        end else if (en_w) begin
            r_wght_d <= wght;
        end
    end

    // Control strobes follow the data by one cycle so the next PE sees them aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl_d <= '0;
        end else begin
            r_ctrl_d <= {en_i, clr_i, en_w, clr_w, en_o, clr_o, mode};
        end
    end

    assign {en_i_d, clr_i_d, en_w_d, clr_w_d, en_o_d, clr_o_d, mode_d} = r_ctrl_d;
    assign wght_d = r_wght_d;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pe_lane #(
            .IWIDTH (IWIDTH),
            .OWIDTH (OWIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_en_ifm  (en_i),
            .i_clr_ifm (clr_i),
            .i_en_acc  (en_o),
            .i_clr_acc (clr_o),
            .i_mode    (pe_mode_t'(mode)),
            .i_ifm     (ifm[k*IWIDTH +: IWIDTH]),
            .i_wght    (r_wght_d),
            .i_ofm     (ofm[k*OWIDTH +: OWIDTH]),
            .o_ifm_d   (ifm_d[k*IWIDTH +: IWIDTH]),
            .o_ofm_d   (ofm_d[k*OWIDTH +: OWIDTH])
`ifdef PE_SAT_EN
            ,
            .o_ovf     (ovf[k])
`endif
        );
    end

endmodule

// File: tb/tb_pe_border_ml.sv
// Directed self-checking bench for pe_border_ml (OWIDTH=17 so overflow is reachable).
module tb_pe_border_ml;

    localparam int IW = 8;
    localparam int OW = 17;
    localparam int LN = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en_i, clr_i, en_w, clr_w, en_o, clr_o, mode;
    logic [LN*IW-1:0]  ifm;
    logic [IW-1:0]     wght;
    logic [LN*OW-1:0]  ofm;
    logic              en_i_d, clr_i_d, en_w_d, clr_w_d, en_o_d, clr_o_d, mode_d;
    logic [LN*IW-1:0]  ifm_d;
    logic [IW-1:0]     wght_d;
    logic [LN*OW-1:0]  ofm_d;
`ifdef PE_SAT_EN
    logic [LN-1:0]     ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pe_border_ml #(.IWIDTH(IW), .OWIDTH(OW), .LANES(LN)) dut (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en_i),
        .clr_i   (clr_i),
        .en_w    (en_w),
        .clr_w   (clr_w),
        .en_o    (en_o),
        .clr_o   (clr_o),
        .mode    (mode),
        .ifm     (ifm),
        .wght    (wght),
        .ofm     (ofm),
        .en_i_d  (en_i_d),
        .clr_i_d (clr_i_d),
        .en_w_d  (en_w_d),
        .clr_w_d (clr_w_d),
        .en_o_d  (en_o_d),
        .clr_o_d (clr_o_d),
        .mode_d  (mode_d),
        .ifm_d   (ifm_d),
        .wght_d  (wght_d),
        .ofm_d   (ofm_d)
`ifdef PE_SAT_EN
        ,
        .ovf     (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [63:0] ofm_lane(input int k);
        logic signed [OW-1:0] v;
        v = ofm_d[k*OW +: OW];
        return 64'(v);
    endfunction

    function automatic logic signed [63:0] ifm_lane(input int k);
        logic signed [IW-1:0] v;
        v = ifm_d[k*IW +: IW];
        return 64'(v);
    endfunction

    function automatic logic [6:0] ctrl_d();
        return {en_i_d, clr_i_d, en_w_d, clr_w_d, en_o_d, clr_o_d, mode_d};
    endfunction

    task automatic set_ifm(input int a0, input int a1, input int a2, input int a3);
        ifm[0*IW +: IW] = IW'(a0);
        ifm[1*IW +: IW] = IW'(a1);
        ifm[2*IW +: IW] = IW'(a2);
        ifm[3*IW +: IW] = IW'(a3);
    endtask

    task automatic set_ofm_all(input int v);
        for (int k = 0; k < LN; k++) ofm[k*OW +: OW] = OW'(v);
    endtask

    task automatic strobes_off();
        {en_i, clr_i, en_w, clr_w, en_o, clr_o} = '0;
    endtask

    int exp_lane [LN];

    initial begin
        rst = 1'b1;
        strobes_off();
        mode = 1'b0;
        ifm  = '0;
        wght = '0;
        ofm  = '0;
        step();
        step();

        check("rst_ofm",  64'(ofm_d), 64'd0);
        check("rst_ifm",  64'(ifm_d), 64'd0);
        check("rst_wght", 64'(wght_d), 64'd0);
        check("rst_ctrl", 64'(ctrl_d()), 64'd0);
`ifdef PE_SAT_EN
        check("rst_ovf",  64'(ovf), 64'd0);
`endif
        rst = 1'b0;

        // Weight-stationary chain
        set_ifm(1, -2, 5, -7);
        wght = 8'sd3;
        en_i = 1'b1;
        en_w = 1'b1;
        step();
        strobes_off();
        check("ws_ifm3", ifm_lane(3), -64'sd7);
        check("ws_wght", 64'(wght_d), 64'd3);
        set_ofm_all(10);
        mode = 1'b0;
        en_o = 1'b1;
        step();
        en_o = 1'b0;
        exp_lane = '{13, 4, 25, -11};
        for (int k = 0; k < LN; k++)
            check($sformatf("ws_ofm%0d", k), ofm_lane(k), 64'(exp_lane[k]));

        // Output-stationary accumulation; upstream ofm must be ignored
        clr_o = 1'b1;
        step();
        clr_o = 1'b0;
        set_ifm(2, 2, 2, 2);
        wght = -8'sd4;
        en_i = 1'b1;
        en_w = 1'b1;
        step();
        strobes_off();
        set_ofm_all(999);
        mode = 1'b1;
        en_o = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            for (int k = 0; k < LN; k++)
                check($sformatf("os_c%0d_l%0d", c, k), ofm_lane(k), 64'(-8 * c));
        end
        clr_o = 1'b1;
        step();
        strobes_off();
        check("os_clr", 64'(ofm_d), 64'd0);

        // Priority: clear beats enable, reset beats everything
        set_ifm(9, 9, 9, 9);
        wght = 8'sd5;
        {en_i, clr_i, en_w, clr_w} = 4'b1111;
        step();
        strobes_off();
        check("pri_ifm",  64'(ifm_d), 64'd0);
        check("pri_wght", 64'(wght_d), 64'd0);
        set_ifm(1, 1, 1, 1);
        wght = 8'sd1;
        en_i = 1'b1;
        en_w = 1'b1;
        step();
        strobes_off();
        en_o = 1'b1;
        step();
        step();
        check("pri_pre_rst", ofm_lane(0), 64'sd2);
        rst  = 1'b1;
        en_i = 1'b1;
        en_w = 1'b1;
        step();
        check("rst_en_ofm",  64'(ofm_d), 64'd0);
        check("rst_en_ctrl", 64'(ctrl_d()), 64'd0);
        check("rst_en_ifm",  64'(ifm_d), 64'd0);
        check("rst_en_wght", 64'(wght_d), 64'd0);
        rst = 1'b0;
        strobes_off();

        // Overflow on lane 2 only, neighbours must stay exact
        set_ifm(2, -1, 127, 1);
        wght = 8'sd127;
        en_i = 1'b1;
        en_w = 1'b1;
        step();
        strobes_off();
        mode = 1'b1;
        en_o = 1'b1;
        for (int c = 0; c < 4; c++) step();
        check("ovf_c4_l2", ofm_lane(2), 64'sd64516);
        check("ovf_c4_l0", ofm_lane(0), 64'sd1016);
`ifdef PE_SAT_EN
        check("ovf_c4_flag", 64'(ovf), 64'd0);
`endif
        step();
`ifdef PE_SAT_EN
        exp_lane = '{1270, -635, 65535, 635};
        check("ovf_c5_flag", 64'(ovf), 64'd4);
`else
        exp_lane = '{1270, -635, -50427, 635};
`endif
        for (int k = 0; k < LN; k++)
            check($sformatf("ovf_c5_l%0d", k), ofm_lane(k), 64'(exp_lane[k]));
        step();
`ifdef PE_SAT_EN
        check("ovf_c6_l2",   ofm_lane(2), 64'sd65535);
        check("ovf_c6_flag", 64'(ovf), 64'd4);
`else
        check("ovf_c6_l2",   ofm_lane(2), -64'sd34298);
`endif
        check("ovf_c6_l0", ofm_lane(0), 64'sd1524);
        strobes_off();
        clr_o = 1'b1;
        step();
        clr_o = 1'b0;
        check("ovf_clr_ofm", 64'(ofm_d), 64'd0);
`ifdef PE_SAT_EN
        check("ovf_clr_flag", 64'(ovf), 64'd0);
`endif

        // Control skew under a random strobe pattern
        for (int i = 0; i < 24; i++) begin
            logic [6:0] pat;
            pat = 7'($urandom_range(0, 127));
            {en_i, clr_i, en_w, clr_w, en_o, clr_o, mode} = pat;
            ifm  = LN*IW'($urandom);
            wght = IW'($urandom);
            step();
            check($sformatf("skew_%0d", i), 64'(ctrl_d()), 64'(pat));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
